// File: rtl/stream_loader_pkg.sv
// Shared types for the stream loader: beat geometry and the loader FSM states.
package stream_loader_pkg;

  localparam int unsigned IBYTES  = 64;
  localparam int unsigned IB_LOG2 = $clog2(IBYTES);
  localparam int unsigned OB_W    = IB_LOG2 + 1;

  typedef logic [7:0] byte_t;
  typedef byte_t [IBYTES-1:0] beat_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } loader_state_t;

endpackage

// File: rtl/stream_loader_if.sv
// Descriptor, memory request/response and output-beat signals of the stream loader.
interface stream_loader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
);
  import stream_loader_pkg::*;

  logic              cvalid;
  logic              cready;
  logic [ADDR_W-1:0] caddr;
  logic [LEN_W-1:0]  clen;

  logic              mreq_valid;
  logic              mreq_ready;
  logic [ADDR_W-1:0] mreq_addr;
  logic              mresp_valid;
  beat_t             mresp_data;

  logic              ovalid;
  logic              oready;
  beat_t             odata;
  logic              olast;
  logic [OB_W-1:0]   obytes;
  logic              busy;

  modport master (
    input  cvalid, caddr, clen, mreq_ready, mresp_valid, mresp_data, oready,
    output cready, mreq_valid, mreq_addr, ovalid, odata, olast, obytes, busy
  );

  modport slave (
    output cvalid, caddr, clen, mreq_ready, mresp_valid, mresp_data, oready,
    input  cready, mreq_valid, mreq_addr, ovalid, odata, olast, obytes, busy
  );

endinterface

// File: rtl/stream_loader_fifo.sv
// Response FIFO of beat_t entries; the caller never pushes when full unless popping.
module stream_loader_fifo
  import stream_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  beat_t din,
  input  logic  pop,
  output beat_t dout,
  output logic  empty,
  output logic  full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  beat_t       mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/stream_loader.sv
// Descriptor-driven beat fetcher feeding the stream buffer with credit-limited reads.
// Optional zero-latency response bypass: define STREAM_LOADER_BYPASS_EN.
module stream_loader
  import stream_loader_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned LEN_W           = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic             clk,
  input logic             rst,
  stream_loader_if.master bus
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  nbeats_q, issued_q, popped_q;
  logic [OB_W-1:0]   lastb_q;
  logic [CW-1:0]     credits_q;

  logic [LEN_W:0]    nb_sum;
  logic [LEN_W-1:0]  nb_calc;
  logic [OB_W-1:0]   lb_calc;
  logic              accept, req_fire, pop, is_last;
  logic              mreq_valid_w, ovalid_w, olast_w, byp;
  logic              f_push, f_pop, f_empty, f_full;
  logic [OB_W-1:0]   obytes_w;
  beat_t             f_dout, head, odata_w;

  // Beat count and tail size are derived once, at descriptor accept.
  assign nb_sum  = {1'b0, bus.clen} + (LEN_W+1)'(IBYTES - 1);
  assign nb_calc = LEN_W'(nb_sum >> IB_LOG2);
  assign lb_calc = (bus.clen[IB_LOG2-1:0] == '0) ? OB_W'(IBYTES)
                                                 : {1'b0, bus.clen[IB_LOG2-1:0]};

  assign accept       = (state_q == S_IDLE) && bus.cvalid;
  assign mreq_valid_w = (state_q == S_FETCH) && (credits_q < CW'(MAX_OUTSTANDING));
  assign req_fire     = mreq_valid_w && bus.mreq_ready;
  assign pop          = ovalid_w && bus.oready;
  assign is_last      = (popped_q == nbeats_q - LEN_W'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.cvalid && bus.clen != '0) state_d = S_FETCH;
      S_FETCH: if (req_fire && (issued_q + LEN_W'(1) == nbeats_q)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DRAIN;
      default: state_d = S_IDLE;
    endcase
    // A bypassed final beat can complete before DRAIN is reached.
    if (state_q != S_IDLE && pop && olast_w) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      nbeats_q  <= '0;
      lastb_q   <= '0;
      issued_q  <= '0;
      popped_q  <= '0;
      credits_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= bus.caddr & ~ADDR_W'(IBYTES - 1);
        nbeats_q <= nb_calc;
        lastb_q  <= lb_calc;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (req_fire) begin
          addr_q   <= addr_q + ADDR_W'(IBYTES);
          issued_q <= issued_q + LEN_W'(1);
        end
        if (pop) popped_q <= popped_q + LEN_W'(1);
      end
      unique case ({req_fire, pop})
        2'b10:   credits_q <= credits_q + CW'(1);
        2'b01:   credits_q <= credits_q - CW'(1);
        default: credits_q <= credits_q;
      endcase
    end
  end

`ifdef STREAM_LOADER_BYPASS_EN
  assign byp = f_empty && bus.mresp_valid && bus.oready && (state_q != S_IDLE);
`else
  assign byp = 1'b0;
`endif

  assign f_push = bus.mresp_valid && (state_q != S_IDLE) && !byp && (!f_full || f_pop);
  assign f_pop  = pop && !f_empty;

  stream_loader_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (f_push),
    .din   (bus.mresp_data),
    .pop   (f_pop),
    .dout  (f_dout),
    .empty (f_empty),
    .full  (f_full)
  );

  assign ovalid_w = !f_empty || byp;
  assign head     = f_empty ? bus.mresp_data : f_dout;
  assign olast_w  = ovalid_w && is_last;
  assign obytes_w = !ovalid_w ? '0 : (olast_w ? lastb_q : OB_W'(IBYTES));

  always_comb begin
    odata_w = '0;
    for (int unsigned i = 0; i < IBYTES; i++) begin
      if (OB_W'(i) < obytes_w) odata_w[i] = head[i];
    end
  end

  assign bus.cready     = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.mreq_valid = mreq_valid_w;
  assign bus.mreq_addr  = addr_q;
  assign bus.ovalid     = ovalid_w;
  assign bus.odata      = odata_w;
  assign bus.olast      = olast_w;
  assign bus.obytes     = obytes_w;

endmodule

// File: doc/stream_loader.md
Name: stream_loader

Overview:
- Upstream feeder of the stream buffer.
- Accepts one stream descriptor (start address, byte length) at a time and issues IBYTES-aligned read requests to memory, limited to MAX_OUTSTANDING requests in flight.
- Collects in-order memory responses in a small FIFO and presents IBYTES-wide beats on a valid/ready port that drives streambuffer ivalid/idata/iready directly.

Parameters:
- ADDR_W, 32, byte-address width
- LEN_W, 16, descriptor length width (bytes)
- MAX_OUTSTANDING, 4, max requests issued but not yet popped at the output; also the response FIFO depth (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cvalid  in  1  descriptor valid
- cready  out  1  descriptor accepted when cvalid&&cready
- caddr  in  ADDR_W  stream start byte address
- clen  in  LEN_W  stream length in bytes
- mreq_valid  out  1  memory read request valid
- mreq_ready  in  1  memory accepts request
- mreq_addr  out  ADDR_W  request address, IBYTES-aligned
- mresp_valid  in  1  response beat, in request order, no backpressure
- mresp_data  in  byte_t[IBYTES]  response data
- ovalid  out  1  output beat valid (to streambuffer ivalid)
- oready  in  1  consumer ready (from streambuffer iready)
- odata  out  byte_t[IBYTES]  output beat
- olast  out  1  final beat of stream
- obytes  out  $clog2(IBYTES)+1  valid bytes in beat, 1..IBYTES
- busy  out  1  descriptor active

Behaviour:
- Reset (rst=0, async): cready=1, mreq_valid=0, ovalid=0, olast=0, obytes=0, odata=0, busy=0. FIFO and counters cleared; state IDLE.
- FSM states:
  - IDLE: cready=1. On accept, latch addr = caddr with low log2(IBYTES) bits forced to 0, nbeats = ceil(clen/IBYTES), rem = clen.
    - clen=0: stay IDLE, no requests, no output.
    - else go to FETCH.
  - FETCH: mreq_valid=1 while credits<MAX_OUTSTANDING. On each mreq_valid&&mreq_ready, addr += IBYTES and issued++. When issued==nbeats go to DRAIN.
  - DRAIN: no requests. When the last beat pops (ovalid&&oready&&olast) go to IDLE. cready rises the next cycle.
- busy = (state!=IDLE).
- Credits:
  - credits++ on request handshake, credits-- on output pop; simultaneous events net zero.
  - Credits bound FIFO occupancy, so mresp_valid never overflows.
- Latency: descriptor accept at cycle 0 → mreq_valid at cycle 1. mresp_valid at cycle k → ovalid at cycle k+1 (registered FIFO).
- Output:
  - FIFO head drives odata. ovalid=FIFO non-empty. Handshake pops on ovalid&&oready.
  - ovalid and payload are held stable until accepted.
  - Beat counter tracks popped beats. olast=1 on beat nbeats-1.
  - obytes=IBYTES except on the last beat: obytes = clen-(nbeats-1)*IBYTES. Bytes ≥ obytes are zeroed.
- FIFO full plus simultaneous push and pop: legal; occupancy unchanged.
- mresp_valid in IDLE (stray response): discarded.
- Reset mid-stream: everything aborted immediately. The memory side must be reset alongside.
- Address wrap past 2^ADDR_W: modulo arithmetic, no error.

Optional Feature:
- STREAM_LOADER_BYPASS_EN
  - Defined: when the FIFO is empty, mresp_valid is high and oready is high, mresp_data passes combinationally to odata (ovalid same cycle, zero latency) and the FIFO is not written.
  - Defined, oready low: the beat is written to the FIFO as usual.
  - Undefined: always 1-cycle registered path as above.
  - Credit accounting is identical in both builds.

Decomposition:
- Shared package holds byte_t, IBYTES (already used by streambuffer), and the FSM state enum loader_state_t.
- One natural sub-module: stream_loader_fifo, a parameterised depth-MAX_OUTSTANDING FIFO of byte_t[IBYTES] with push/pop/empty/full and the same async active-low rst.

Test Plan (package IBYTES=64, MAX_OUTSTANDING=4):
- caddr=0x1000, clen=256, mreq_ready=1, responses 3 cycles after each request, oready=1 → requests 0x1000/0x1040/0x1080/0x10C0 on 4 consecutive cycles; 4 output beats, olast on 4th, obytes=64 each; cready high after last pop.
- clen=100, caddr=0x2023 → requests 0x2000 and 0x2040 only; beat 2 obytes=36, olast=1, bytes 36..63 zero.
- clen=640, oready=0 → exactly 4 requests issued then mreq_valid=0. Raise oready → one new request per pop; 10 beats total, no data loss.
- oready toggling every cycle (as streambuffer iready), clen=320 → 5 beats delivered in order, odata stable while ovalid&&!oready.
- clen=0 → no mreq_valid, no ovalid, cready=1 the following cycle.
- rst asserted after 2 of 8 beats popped → all outputs at reset values same cycle; new descriptor after release starts cleanly at its own address.
